cp0_unit: RTL and testbench

CP0_UNIT -- requirements
Module: cp0_unit

---
 rtl/cp0_unit.sv | 111 +++++++++++
 tb/tb_cp0_unit.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/cp0_unit.sv
// CP0 coprocessor: Count/Compare timer, Status/Cause/EPC, trap entry and eret.
// Exception priority is accepted trap > eret > mtc0.
module cp0_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mfc0,
  input  logic        mtc0,
  input  logic        exception,
  input  logic        eret,
  input  logic [4:0]  cause,
  input  logic [31:0] pc,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        exc_redirect,
  output logic [31:0] exc_addr,
  output logic [31:0] status,
  output logic        timer_irq
);

  localparam logic [4:0]  A_COUNT   = 5'd9;
  localparam logic [4:0]  A_COMPARE = 5'd11;
  localparam logic [4:0]  A_STATUS  = 5'd12;
  localparam logic [4:0]  A_CAUSE   = 5'd13;
  localparam logic [4:0]  A_EPC     = 5'd14;
  localparam logic [31:0] EXC_VEC   = 32'h0040_0004;

  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic [31:0] r_status;
  logic [31:0] r_cause;
  logic [31:0] r_epc;

  logic        w_mask;
  logic        w_accept;
  logic        w_wr;
  logic        w_cmp_wr;
  logic        w_match;
  logic [31:0] w_count_nxt;

  always_comb begin
    w_mask = 1'b0;
    case (cause)
      5'd8:    w_mask = r_status[1];
      5'd9:    w_mask = r_status[2];
      5'd13:   w_mask = r_status[3];
      default: w_mask = 1'b0;
    endcase
  end

  assign w_accept = exception & r_status[0] & w_mask;
  // mtc0 only takes effect when neither a trap nor eret claims the cycle
  assign w_wr     = mtc0 & ~w_accept & ~eret;
  assign w_cmp_wr = w_wr & (addr == A_COMPARE);

  assign w_count_nxt = (w_wr && addr == A_COUNT) ? wdata
                                                 : r_count + 32'd1;
  assign w_match = (w_count_nxt == r_compare) && (r_compare != 32'd0);

  always_comb begin
    rdata = 32'd0;
    if (mfc0) begin
      case (addr)
        A_COUNT:   rdata = r_count;
        A_COMPARE: rdata = r_compare;
        A_STATUS:  rdata = r_status;
        A_CAUSE:   rdata = r_cause;
        A_EPC:     rdata = r_epc;
        default:   rdata = 32'd0;
      endcase
    end
  end

  assign exc_redirect = w_accept | eret;
  assign exc_addr     = w_accept ? EXC_VEC :
                        eret     ? r_epc   : 32'd0;
  assign status       = r_status;
  assign timer_irq    = r_cause[15];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count   <= 32'd0;
      r_compare <= 32'd0;
      r_status  <= 32'd0;
      r_cause   <= 32'd0;
      r_epc     <= 32'd0;
    end else begin
      r_count <= w_count_nxt;
      if (w_accept) begin
        r_epc        <= pc;
        r_cause[6:2] <= cause;
        r_status     <= r_status << 5;
      end else if (eret) begin
        r_status <= r_status >> 5;
      end else if (w_wr) begin
        case (addr)
          A_COMPARE: r_compare      <= wdata;
          A_STATUS:  r_status       <= wdata;
          A_CAUSE:   r_cause[9:8]   <= wdata[9:8];
          A_EPC:     r_epc          <= wdata;
          default:   ;
        endcase
      end
      if (w_cmp_wr)
        r_cause[15] <= 1'b0;
      else if (w_match)
        r_cause[15] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cp0_unit.sv
// Scoreboard bench for cp0_unit: directed scenarios then random traffic
// against a register-array reference model.
module tb_cp0_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mfc0, mtc0, exception, eret;
  logic [4:0]  cause, addr;
  logic [31:0] pc, wdata;
  logic [31:0] rdata, exc_addr, status;
  logic        exc_redirect, timer_irq;

  cp0_unit dut (
    .clk(clk), .rst_n(rst_n), .mfc0(mfc0), .mtc0(mtc0),
    .exception(exception), .eret(eret), .cause(cause), .pc(pc),
    .addr(addr), .wdata(wdata), .rdata(rdata),
    .exc_redirect(exc_redirect), .exc_addr(exc_addr),
    .status(status), .timer_irq(timer_irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        red;
    logic [31:0] xaddr;
    logic [31:0] st;
    logic        irq;
  } exp_t;

  exp_t q[$];
  event ev_issue;
  int   checks = 0;
  int   errors = 0;

  // Reference state, indexed by CP0 register number
  logic [31:0] m [0:31];

  function automatic bool_impl(input logic [4:0] a);
    return a == 9 || a == 11 || a == 12 || a == 13 || a == 14;
  endfunction

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp,
               $time);
    end
  endtask

  task automatic drive(input bit r, input bit rd, input bit wr,
                       input bit ex, input bit er, input logic [4:0] c,
                       input logic [31:0] p, input logic [4:0] a,
                       input logic [31:0] d);
    exp_t e;
    bit acc;
    logic [31:0] cnt, cmp, st;
    @(negedge clk);
    rst_n = r; mfc0 = rd; mtc0 = wr; exception = ex; eret = er;
    cause = c; pc = p; addr = a; wdata = d;
    st  = m[12];
    acc = ex && st[0] && ((c == 8 && st[1]) || (c == 9 && st[2]) ||
                          (c == 13 && st[3]));
    e.rdata = (rd && bool_impl(a)) ? m[a] : 32'd0;
    e.red   = acc || er;
    e.xaddr = acc ? 32'h0040_0004 : (er ? m[14] : 32'd0);
    e.st    = st;
    e.irq   = m[13][15];
    q.push_back(e);
    ->ev_issue;
    if (!r) begin
      foreach (m[i]) m[i] = 32'd0;
    end else begin
      cmp = m[11];
      cnt = m[9] + 32'd1;
      if (acc) begin
        m[14] = p;
        m[13][6:2] = c;
        m[12] = st << 5;
      end else if (er) begin
        m[12] = st >> 5;
      end else if (wr) begin
        if (a == 9)  cnt = d;
        if (a == 11) m[11] = d;
        if (a == 12) m[12] = d;
        if (a == 13) m[13][9:8] = d[9:8];
        if (a == 14) m[14] = d;
      end
      m[9] = cnt;
      if (!acc && !er && wr && a == 11) m[13][15] = 1'b0;
      else if (cnt == cmp && cmp != 0)  m[13][15] = 1'b1;
    end
  endtask

  task automatic rd_reg(input logic [4:0] a);
    drive(1, 1, 0, 0, 0, 0, 0, a, 0);
  endtask

  task automatic wr_reg(input logic [4:0] a, input logic [31:0] d);
    drive(1, 0, 1, 0, 0, 0, 0, a, d);
  endtask

  task automatic trap(input logic [4:0] c, input logic [31:0] p);
    drive(1, 0, 0, 1, 0, c, p, 0, 0);
  endtask

  task automatic do_eret();
    drive(1, 0, 0, 0, 1, 0, 0, 0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(ev_issue);
      #2;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard: got empty queue expected entry");
      end else begin
        e = q.pop_front();
        check("rdata", rdata, e.rdata);
        check("exc_redirect", {31'd0, exc_redirect}, {31'd0, e.red});
        check("exc_addr", exc_addr, e.xaddr);
        check("status", status, e.st);
        check("timer_irq", {31'd0, timer_irq}, {31'd0, e.irq});
      end
    end
  end

  initial begin : stim
    logic [4:0]  a, c;
    logic [31:0] d;
    int          k;
    rst_n = 0; mfc0 = 0; mtc0 = 0; exception = 0; eret = 0;
    cause = 0; pc = 0; addr = 0; wdata = 0;
    repeat (2) @(posedge clk);
    foreach (m[i]) m[i] = 32'd0;

    rd_reg(9); rd_reg(11); rd_reg(12); rd_reg(13); rd_reg(14);

    wr_reg(12, 32'h0000_000F);
    trap(8, 32'h0040_0020);
    rd_reg(14); rd_reg(13); rd_reg(12);
    do_eret();
    rd_reg(12);

    wr_reg(12, 32'h0000_000D);
    trap(9, 32'h0040_0100);
    rd_reg(14); rd_reg(13); rd_reg(12);
    trap(13, 32'h0040_0200);
    rd_reg(14); rd_reg(13);
    trap(13, 32'h0040_0300);
    do_eret();

    wr_reg(9, 32'd0);
    wr_reg(11, 32'd5);
    repeat (6) rd_reg(13);
    wr_reg(11, 32'd0);
    rd_reg(13);
    wr_reg(9, 32'hFFFF_FFFF);
    rd_reg(9);

    wr_reg(12, 32'h0000_000F);
    drive(1, 0, 1, 1, 0, 8, 32'h0040_0040, 12, 32'd0);
    rd_reg(12);
    drive(0, 1, 1, 0, 1, 0, 0, 12, 32'h1234_5678);
    rd_reg(9); rd_reg(12); rd_reg(13); rd_reg(14); rd_reg(11);

    for (int i = 0; i < 600; i++) begin
      k = $urandom_range(0, 5);
      a = (k < 5) ? 5'(9 + (k == 0 ? 0 : k + 1)) : 5'($urandom);
      if (a == 10) a = 11;
      k = $urandom_range(0, 3);
      c = (k == 0) ? 5'd8 : (k == 1) ? 5'd9 : (k == 2) ? 5'd13
                                                       : 5'($urandom);
      k = $urandom_range(0, 3);
      d = (k == 0) ? $urandom : (k == 1) ? 32'hFFFF_FFFE
                                         : 32'($urandom_range(0, 15));
      drive($urandom_range(0, 63) != 0, $urandom_range(0, 1),
            $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 7) == 0, c, $urandom, a, d);
    end

    @(negedge clk);
    mfc0 = 0; mtc0 = 0; exception = 0; eret = 0;
    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
